// File: rtl/gf_pow_seq.sv
// -----------------------------------------------------------------------------
// gf_pow_seq
//
// Multi-cycle GF(2^8) exponentiation unit (result = base^exp) for use as a
// custom-instruction execution resource. Left-to-right square-and-multiply
// over a single shared 8x8 GF(2^8) multiplier: one product per cycle, used
// by SQUARE (acc*acc) or by MULT (acc*base).
//
// Optional feature (compile-time macro GF_POW_INV_EN):
//   defined     : inv = 1 at start forces the exponent to 8'd254, which yields
//                 the multiplicative inverse (0 maps to 0).
//   not defined : inv is present but ignored; exp is always used.
//
// Parameters:
//   POLY  low 8 bits of the reduction polynomial x^8 + POLY (0x1B = AES)
//   XLEN  width of rd_data; the 8-bit result is zero-extended into it
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   request, sampled only in IDLE
//   abort      in   synchronous cancel of an in-flight operation
//   inv        in   inverse request (see optional feature)
//   base       in   operand a, captured on start
//   exp        in   exponent e, captured on start
//   busy       out  high while in SQUARE or MULT
//   done       out  one-cycle pulse; rd_data valid from this cycle onward
//   rd_data    out  {zeros, result}; held until the next done
//   dbg_state  out  current FSM state (0 IDLE, 1 SQUARE, 2 MULT, 3 DONE)
//
// Handshake: start is a level sampled only while the FSM is IDLE; anything
// on start/base/exp/inv outside that cycle is ignored. busy covers exactly
// the SQUARE/MULT cycles; done pulses for the single DONE cycle and rd_data
// is already updated in that cycle. abort is honoured only in SQUARE/MULT,
// and wins over start when both are high in IDLE.
// -----------------------------------------------------------------------------
module gf_pow_seq #(
   parameter logic [7:0] POLY = 8'h1B,
   parameter int         XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic            inv,
   input  logic [7:0]      base,
   input  logic [7:0]      exp,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] rd_data,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SQUARE = 2'd1,
      S_MULT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t     state_q;
   logic [7:0] acc_q;
   logic [7:0] base_q;
   logic [7:0] exp_q;
   logic [2:0] idx_q;
   logic       busy_q;
   logic       done_q;
   logic [7:0] res_q;

   logic [7:0] mul_b;
   logic [7:0] acc_d;
   logic [7:0] exp_eff;

   // Full carry-less 8x8 product followed by reduction of every high bit
   // (14 down to 8). Each x^i with i >= 8 is rewritten as x^(i-8) * POLY;
   // working from the top down means any bit re-set by a lower fold is
   // still visited later, so the result always fits in 8 bits.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ ({7'b0, a} << i);
      end
      for (int i = 14; i >= 8; i--) begin
         if (p[i]) begin
            p[i-8 +: 8] = p[i-8 +: 8] ^ POLY;
            p[i]        = 1'b0;
         end
      end
      return p[7:0];
   endfunction

   // The one multiplier: second operand is base in MULT, acc otherwise.
   always_comb begin
      mul_b = acc_q;
      if (state_q == S_MULT) mul_b = base_q;
      acc_d = gf_mul(acc_q, mul_b);
   end

`ifdef GF_POW_INV_EN
   // a^254 = a^-1 in GF(2^8) for nonzero a, and 0^254 = 0.
   always_comb begin
      exp_eff = exp;
      if (inv) exp_eff = 8'd254;
   end
`else
   logic unused_inv;
   assign unused_inv = inv;
   always_comb begin
      exp_eff = exp;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= 8'd0;
         base_q  <= 8'd0;
         exp_q   <= 8'd0;
         idx_q   <= 3'd7;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= 8'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  base_q  <= base;
                  exp_q   <= exp_eff;
                  acc_q   <= 8'd1;
                  idx_q   <= 3'd7;
                  busy_q  <= 1'b1;
                  state_q <= S_SQUARE;
               end
            end

            S_SQUARE: begin
               if (abort) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  acc_q <= acc_d;
                  if (exp_q[idx_q]) begin
                     state_q <= S_MULT;
                  end else if (idx_q == 3'd0) begin
                     // Result is published on entry to DONE so that rd_data
                     // is already valid while done is high.
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     res_q   <= acc_d;
                     state_q <= S_DONE;
                  end else begin
                     idx_q <= idx_q - 3'd1;
                  end
               end
            end

            S_MULT: begin
               if (abort) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  acc_q <= acc_d;
                  if (idx_q == 3'd0) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     res_q   <= acc_d;
                     state_q <= S_DONE;
                  end else begin
                     idx_q   <= idx_q - 3'd1;
                     state_q <= S_SQUARE;
                  end
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_data   = {{(XLEN-8){1'b0}}, res_q};
   assign dbg_state = state_q;

endmodule
